// File: rtl/handshake_constant_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : handshake_constant_repeat
//  Purpose  : Emits a burst of REPEAT output tokens for every accepted control
//             token. The first word of each burst is VALUE and each following
//             word is the previous one plus STRIDE, wrapping modulo
//             2^DATA_WIDTH.
//  Ports    : clk        - clock, all state updates on its rising edge
//             rst        - synchronous active-high reset
//             ctrl_valid - trigger token present
//             ctrl_ready - trigger token accepted this cycle
//             outs       - constant/sequence data (registered)
//             outs_valid - outs holds a valid token (registered)
//             outs_ready - consumer accepts token
//  Revision : 1.0 - initial release
// ============================================================================
module handshake_constant_repeat #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VALUE      = '1,
  parameter int                    REPEAT     = 1,
  parameter logic [DATA_WIDTH-1:0] STRIDE     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int              CNT_W   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(REPEAT - 1);

  generate
    if (REPEAT < 1 || DATA_WIDTH < 1) begin : g_param_err
      $error("handshake_constant_repeat: REPEAT and DATA_WIDTH must both be >= 1");
    end
  endgenerate

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  logic w_last;
  logic w_accept;
  logic w_xfer;

  assign w_last   = (cnt_q == C_LAST);
  // A new trigger may only land when idle or when the final beat of the
  // current burst leaves this very cycle, which gives back-to-back bursts.
  assign ctrl_ready = !valid_q || (outs_ready && w_last);
  assign w_accept   = ctrl_valid && ctrl_ready;
  assign w_xfer     = valid_q && outs_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (w_xfer) begin
      if (!w_last) begin
        cnt_d  = cnt_q + CNT_W'(1);
        data_d = data_q + STRIDE;
      end else begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end
    // Accept overrides the last-beat retirement so the reload happens
    // without an idle cycle.
    if (w_accept) begin
      valid_d = 1'b1;
      data_d  = VALUE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= VALUE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outs       = data_q;
  assign outs_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_handshake_constant_repeat
//  Purpose  : Directed self-checking bench for handshake_constant_repeat with a
//             scoreboard for the main instance (8-bit, F0, REPEAT 3, STRIDE 1),
//             plus a wrap instance (FE) and a single-token instance (REPEAT 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_constant_repeat;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic       ctrl_valid, ctrl_ready, outs_valid, outs_ready;
  logic [7:0] outs;
  // wrap instance
  logic       c2_valid, c2_ready, o2_valid, o2_ready;
  logic [7:0] o2;
  // single-token instance
  logic       c3_valid, c3_ready, o3_valid, o3_ready;
  logic [7:0] o3;

  handshake_constant_repeat #(.DATA_WIDTH(8), .VALUE(8'hF0), .REPEAT(3), .STRIDE(8'h01)) dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready));

  handshake_constant_repeat #(.DATA_WIDTH(8), .VALUE(8'hFE), .REPEAT(3), .STRIDE(8'h01)) dut_wrap (
    .clk(clk), .rst(rst), .ctrl_valid(c2_valid), .ctrl_ready(c2_ready),
    .outs(o2), .outs_valid(o2_valid), .outs_ready(o2_ready));

  handshake_constant_repeat #(.DATA_WIDTH(8), .VALUE(8'h5A), .REPEAT(1), .STRIDE(8'h00)) dut_one (
    .clk(clk), .rst(rst), .ctrl_valid(c3_valid), .ctrl_ready(c3_ready),
    .outs(o3), .outs_valid(o3_valid), .outs_ready(o3_ready));

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_acc = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  // Scoreboard: each accepted trigger enqueues its three expected words, each
  // output transfer dequeues one. Reset discards whatever is outstanding.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (outs_valid && outs_ready) begin
        if (sb_q.size() > 0) chk("sb_data", {24'h0, outs}, {24'h0, sb_q.pop_front()});
        else                 chk("sb_underflow", sb_q.size(), 1);
      end
      if (ctrl_valid && ctrl_ready) begin
        n_acc++;
        sb_q.push_back(8'hF0);
        sb_q.push_back(8'hF1);
        sb_q.push_back(8'hF2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc0;
    logic [7:0] e;

    rst = 1'b1; ctrl_valid = 1'b1; outs_ready = 1'b0;
    c2_valid = 1'b0; o2_ready = 1'b0; c3_valid = 1'b0; o3_ready = 1'b0;
    tick; tick;
    rst = 1'b0; ctrl_valid = 1'b0;
    samp;
    // reset state; trigger held during reset must not start a burst
    chk("rst_valid", outs_valid, 0);
    chk("rst_ready", ctrl_ready, 1);
    chk("rst_outs", outs, 8'hF0);
    chk("rst_outs_wrap", o2, 8'hFE);
    tick;

    // single pulse
    ctrl_valid = 1'b1; outs_ready = 1'b1;
    samp;
    chk("pulse_ready", ctrl_ready, 1);
    tick;
    ctrl_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp;
      chk("pulse_valid", outs_valid, 1);
      chk("pulse_outs", outs, 8'hF0 + i);
      chk("pulse_ctrl_ready", ctrl_ready, (i == 2) ? 1 : 0);
      tick;
    end
    samp;
    chk("pulse_idle", outs_valid, 0);
    tick;

    // sustained trigger: back-to-back bursts with no bubble
    acc0 = n_acc;
    ctrl_valid = 1'b1;
    samp;
    tick;
    for (int i = 0; i < 6; i++) begin
      samp;
      chk("cont_valid", outs_valid, 1);
      chk("cont_outs", outs, 8'hF0 + (i % 3));
      chk("cont_ctrl_ready", ctrl_ready, (i % 3 == 2) ? 1 : 0);
      tick;
    end
    ctrl_valid = 1'b0;

    // third burst: stall while F1 is presented
    samp;
    chk("stall_pre", outs, 8'hF0);
    tick;
    outs_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp;
      chk("stall_valid", outs_valid, 1);
      chk("stall_outs", outs, 8'hF1);
      chk("stall_ctrl_ready", ctrl_ready, 0);
      tick;
    end
    outs_ready = 1'b1;
    samp; chk("stall_f1", outs, 8'hF1); tick;
    samp; chk("stall_f2", outs, 8'hF2); chk("stall_f2_ready", ctrl_ready, 1); tick;
    samp; chk("stall_idle", outs_valid, 0);
    chk("cont_accepts", n_acc - acc0, 3);
    tick;

    // reset right after F1 transfers: F2 is discarded
    ctrl_valid = 1'b1;
    samp; tick;
    ctrl_valid = 1'b0;
    samp; chk("rb_f0", outs, 8'hF0); tick;
    samp; chk("rb_f1", outs, 8'hF1); tick;
    rst = 1'b1;
    samp; tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp;
      chk("rb_valid", outs_valid, 0);
      chk("rb_ready", ctrl_ready, 1);
      tick;
    end

    // wrap instance: FE, FF, 00
    c2_valid = 1'b1; o2_ready = 1'b1;
    samp; tick;
    c2_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp;
      e = 8'hFE + 8'(i);
      chk("wrap_valid", o2_valid, 1);
      chk("wrap_outs", o2, e);
      tick;
    end
    samp; chk("wrap_idle", o2_valid, 0); tick;

    // single-token instance: one VALUE per trigger, full throughput
    c3_valid = 1'b1; o3_ready = 1'b1;
    samp; chk("one_ready0", c3_ready, 1); tick;
    for (int i = 0; i < 3; i++) begin
      samp;
      chk("one_valid", o3_valid, 1);
      chk("one_outs", o3, 8'h5A);
      chk("one_ready", c3_ready, 1);
      tick;
    end
    c3_valid = 1'b0;
    samp; chk("one_last", o3_valid, 1); tick;
    samp; chk("one_idle", o3_valid, 0); tick;

    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/handshake_constant_repeat.md
HANDSHAKE_CONSTANT_REPEAT -- requirements
Module: handshake_constant_repeat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of outs.
REQ-002 SHALL have parameter VALUE, default all-ones of DATA_WIDTH, first data word emitted per ctrl token.
REQ-003 SHALL have parameter REPEAT, default 1, number of output tokens emitted per accepted ctrl token.
REQ-004 SHALL have parameter STRIDE, default 0, increment added to data between successive tokens of one burst.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ctrl_valid, input, 1, trigger token present.
REQ-008 SHALL have port ctrl_ready, output, 1, trigger token accepted this cycle.
REQ-009 SHALL have port outs, output, DATA_WIDTH, constant/sequence data.
REQ-010 SHALL have port outs_valid, output, 1, outs holds a valid token.
REQ-011 SHALL have port outs_ready, input, 1, consumer accepts token.

Function
REQ-012 SHALL hold state: out_valid register, out_data register (DATA_WIDTH), beat counter cnt of width max(1, clog2(REPEAT)).
REQ-013 SHALL drive outs_valid and outs directly from registers; no combinational path ctrl_valid -> outs_valid or ctrl -> outs.
REQ-014 SHALL drive ctrl_ready = !out_valid || (outs_ready && cnt == REPEAT-1) (combinational).
REQ-015 SHALL define ctrl accept = ctrl_valid && ctrl_ready; output transfer = outs_valid && outs_ready.
REQ-016 On ctrl accept: out_valid <= 1, out_data <= VALUE, cnt <= 0; first token visible the cycle after accept (latency 1).
REQ-017 On output transfer with cnt < REPEAT-1: cnt <= cnt+1, out_data <= out_data + STRIDE modulo 2^DATA_WIDTH, out_valid stays 1.
REQ-018 On output transfer with cnt == REPEAT-1 and no ctrl accept in same cycle: out_valid <= 0, cnt <= 0.
REQ-019 On last-beat transfer and ctrl accept in same cycle: reload per REQ-016; no bubble, sustained throughput 1 token/cycle.
REQ-020 While outs_valid=1 and outs_ready=0: outs, outs_valid and cnt SHALL remain stable.
REQ-021 A ctrl token SHALL never be accepted while a burst has beats remaining other than the final beat transferring that cycle.
REQ-022 STRIDE=0 SHALL yield REPEAT identical VALUE tokens; REPEAT=1 SHALL behave as a registered single-token constant.
REQ-023 Arithmetic SHALL wrap silently at 2^DATA_WIDTH; no saturation, no overflow flag.
REQ-024 REPEAT < 1 or DATA_WIDTH < 1 SHALL be a parameter error flagged at elaboration.

Reset
REQ-025 While rst=1 at a clock edge: out_valid <= 0, cnt <= 0, out_data <= VALUE.
REQ-026 After reset: outs_valid=0, outs=VALUE, ctrl_ready=1.
REQ-027 Reset mid-burst SHALL discard remaining beats; outs_valid=0 the cycle after the reset edge; no resumption.
REQ-028 A ctrl_valid asserted during a reset cycle SHALL NOT be accepted as a burst (reset has priority).

Verification (DATA_WIDTH=8, VALUE=8'hF0, REPEAT=3, STRIDE=1 unless stated)
REQ-029 Reset 2 cycles, ctrl_valid=0 -> outs_valid=0, ctrl_ready=1, outs=8'hF0.
REQ-030 One ctrl pulse, outs_ready=1 -> outs F0,F1,F2 on 3 consecutive cycles starting 1 cycle after accept; ctrl_ready=0 on F0,F1 cycles, 1 on F2 cycle; outs_valid=0 afterwards.
REQ-031 ctrl_valid held high, outs_ready=1 -> continuous F0,F1,F2,F0,F1,F2 with no idle cycle; exactly one ctrl accept per 3 transfers.
REQ-032 outs_ready=0 for 4 cycles while F1 presented -> F1 and outs_valid stable all 4 cycles, ctrl_ready=0; then F1,F2 transfer.
REQ-033 VALUE=8'hFE, STRIDE=1 -> FE,FF,00 (wrap).
REQ-034 rst=1 for one cycle right after F1 transfer -> outs_valid=0 next cycle, F2 never emitted, ctrl_ready=1.
